mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two requesters (p0, p1) share a single req/gnt/rvalid memory port, with at
//   most one transaction outstanding at a time. If both ports request in the
//   same IDLE cycle, a 1-bit priority pointer picks the winner. After each
//   completed response the pointer moves to the port that did not own that
//   transaction.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_req_i/pN_gnt_o            per-requester handshake (N = 0, 1)
//   pN_addr_i/wdata_i/we_i/be_i  per-requester request fields
//   pN_rvalid_o/rdata_o/error_o  per-requester response (zero unless valid)
//   mem_req_o/addr/wdata/we/be   downstream request (fields zero when idle)
//   mem_gnt_i/rvalid_i/rdata_i/error_i  downstream grant and response
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      p0_req_i,
    output logic                      p0_gnt_o,
    output logic                      p0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     p0_addr_i,
    input  logic [DATA_WIDTH-1:0]     p0_wdata_i,
    input  logic                      p0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   p0_be_i,
    output logic [DATA_WIDTH-1:0]     p0_rdata_o,
    output logic                      p0_error_o,

    input  logic                      p1_req_i,
    output logic                      p1_gnt_o,
    output logic                      p1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     p1_addr_i,
    input  logic [DATA_WIDTH-1:0]     p1_wdata_i,
    input  logic                      p1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   p1_be_i,
    output logic [DATA_WIDTH-1:0]     p1_rdata_o,
    output logic                      p1_error_o,

    output logic                      mem_req_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_error_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    state_t r_state;
    logic   r_owner;    // port owning the in-flight transaction
    logic   r_ptr;      // port favoured on a simultaneous request

    logic   w_any_req;
    logic   w_winner;
    logic   w_sel;
    logic   w_mem_req;
    logic   w_gnt;
    logic   w_rvalid;

    always_comb begin
        w_any_req = p0_req_i | p1_req_i;
        if (p0_req_i && p1_req_i) begin
            w_winner = r_ptr;
        end else begin
            w_winner = p1_req_i;
        end
        // In IDLE the winner is forwarded in the same cycle; once in REQ the
        // registered owner is held so the other port cannot steal the bus.
        w_sel     = (r_state == ST_IDLE) ? w_winner : r_owner;
        // rst_n gates the combinational paths so all outputs drop to zero
        // the moment reset is asserted, not only at the next edge.
        w_mem_req = rst_n & (((r_state == ST_IDLE) & w_any_req) | (r_state == ST_REQ));
        w_gnt     = w_mem_req & mem_gnt_i;
        w_rvalid  = rst_n & (r_state == ST_RESP) & mem_rvalid_i;
    end

    always_comb begin
        mem_req_o   = w_mem_req;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        if (w_mem_req) begin
            if (w_sel) begin
                mem_addr_o  = p1_addr_i;
                mem_wdata_o = p1_wdata_i;
                mem_we_o    = p1_we_i;
                mem_be_o    = p1_be_i;
            end else begin
                mem_addr_o  = p0_addr_i;
                mem_wdata_o = p0_wdata_i;
                mem_we_o    = p0_we_i;
                mem_be_o    = p0_be_i;
            end
        end

        p0_gnt_o    = w_gnt & ~w_sel;
        p1_gnt_o    = w_gnt &  w_sel;

        p0_rvalid_o = w_rvalid & ~r_owner;
        p1_rvalid_o = w_rvalid &  r_owner;
        p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
        p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;
        p0_error_o  = p0_rvalid_o & mem_error_i;
        p1_error_o  = p1_rvalid_o & mem_error_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_state <= mem_gnt_i ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid_i) begin
                        r_ptr   <= ~r_owner;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req_i, p1_req_i;
    logic        p0_gnt_o, p1_gnt_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i;
    logic        p0_we_i, p1_we_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_error_o, p1_error_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_error_i;
    logic [31:0] mem_rdata_i;

    int checks;
    int failures;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_rdata_o(p0_rdata_o), .p0_error_o(p0_error_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_rdata_o(p1_rdata_o), .p1_error_o(p1_error_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_error_i(mem_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled #1 later, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_req_i = 0; p1_req_i = 0;
        p0_addr_i = '0; p1_addr_i = '0; p0_wdata_i = '0; p1_wdata_i = '0;
        p0_we_i = 0; p1_we_i = 0; p0_be_i = '0; p1_be_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_error_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        p0_req_i = 1; p0_addr_i = 32'h0000_0100; p0_be_i = 4'hF; mem_gnt_i = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        #2;
        checks++;
        if ({mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o});
        end
        checks++;
        if ({mem_addr_o, mem_be_o, p0_rdata_o, p1_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h be=%h rd0=%h rd1=%h exp=0",
                     mem_addr_o, mem_be_o, p0_rdata_o, p1_rdata_o);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        p0_req_i = 1; p0_addr_i = 32'h0010_0000; p0_we_i = 0; p0_be_i = 4'hF;
        mem_gnt_i = 1;
        #1;
        checks++;
        if ({mem_req_o, p0_gnt_o, p1_gnt_o, mem_we_o} !== 4'b1100 || mem_addr_o !== 32'h0010_0000) begin
            failures++;
            $display("FAIL read_issue got req/g0/g1/we=%b addr=%h exp=1100 addr=00100000",
                     {mem_req_o, p0_gnt_o, p1_gnt_o, mem_we_o}, mem_addr_o);
        end
        step();
        p0_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_ABCD;
        #1;
        checks++;
        if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'h1234_ABCD || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL read_resp got rv0=%b rd0=%h req=%b exp rv0=1 rd0=1234abcd req=0",
                     p0_rvalid_o, p0_rdata_o, mem_req_o);
        end
        checks++;
        if ({p1_gnt_o, p1_rvalid_o, p1_error_o} !== 3'b0 || p1_rdata_o !== '0) begin
            failures++;
            $display("FAIL read_p1_quiet got g1/rv1/err1=%b rd1=%h exp=000 0",
                     {p1_gnt_o, p1_rvalid_o, p1_error_o}, p1_rdata_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_alternation();
        logic exp_w;
        do_reset();
        p0_addr_i = 32'h0000_A000; p1_addr_i = 32'h0000_B000;
        p0_be_i = 4'hF; p1_be_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            exp_w = r[0];
            p0_req_i = 1; p1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 0;
            #1;
            checks++;
            if (p0_gnt_o !== ~exp_w || p1_gnt_o !== exp_w ||
                mem_addr_o !== (exp_w ? 32'h0000_B000 : 32'h0000_A000)) begin
                failures++;
                $display("FAIL alt_grant round=%0d got g0=%b g1=%b addr=%h exp winner=p%0d",
                         r, p0_gnt_o, p1_gnt_o, mem_addr_o, exp_w);
            end
            step();
            mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h100 + r;
            #1;
            checks++;
            if (p0_rvalid_o !== ~exp_w || p1_rvalid_o !== exp_w || mem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL alt_resp round=%0d got rv0=%b rv1=%b req=%b exp winner=p%0d req=0",
                         r, p0_rvalid_o, p1_rvalid_o, mem_req_o, exp_w);
            end
            step();
        end
        clear_inputs();
    endtask

    // Pointer is 0 on entry (last owner was p1).
    task automatic test_stall();
        p1_req_i = 1; p1_addr_i = 32'h0000_2000; p1_wdata_i = 32'hDEAD_BEEF;
        p1_we_i = 1; p1_be_i = 4'b0011;
        p0_addr_i = 32'h0000_3000; p0_wdata_i = 32'h1111_2222; p0_be_i = 4'hF;
        mem_gnt_i = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_2000 || mem_wdata_o !== 32'hDEAD_BEEF ||
                mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 || p0_gnt_o !== 1'b0 || p1_gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got req=%b addr=%h wd=%h we=%b be=%b g0=%b g1=%b exp p1 fields, no gnt",
                         c, mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o, p0_gnt_o, p1_gnt_o);
            end
            step();
            p0_req_i = 1;
        end
        mem_gnt_i = 1;
        #1;
        checks++;
        if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0 || mem_addr_o !== 32'h0000_2000) begin
            failures++;
            $display("FAIL stall_gnt got g0=%b g1=%b addr=%h exp g0=0 g1=1 addr=00002000",
                     p0_gnt_o, p1_gnt_o, mem_addr_o);
        end
        step();
        p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        #1;
        checks++;
        if (p1_rvalid_o !== 1'b1 || p0_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || p0_gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_resp got rv0=%b rv1=%b req=%b g0=%b exp rv1=1 only",
                     p0_rvalid_o, p1_rvalid_o, mem_req_o, p0_gnt_o);
        end
        step();
        mem_rvalid_i = 0; mem_gnt_i = 1;
        #1;
        checks++;
        if (p0_gnt_o !== 1'b1 || mem_addr_o !== 32'h0000_3000 || mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_p0_next got g0=%b addr=%h we=%b exp g0=1 addr=00003000 we=0",
                     p0_gnt_o, mem_addr_o, mem_we_o);
        end
        step();
        p0_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_spurious_rvalid();
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0001;
        #1;
        checks++;
        if ({p0_rvalid_o, p1_rvalid_o, mem_req_o} !== 3'b0 || p0_rdata_o !== '0 || p1_rdata_o !== '0) begin
            failures++;
            $display("FAIL spur_idle got rv0=%b rv1=%b req=%b rd0=%h exp all 0",
                     p0_rvalid_o, p1_rvalid_o, mem_req_o, p0_rdata_o);
        end
        step();
        // p0 requests without grant -> REQ, with rvalid still pulsing.
        p0_req_i = 1; p0_addr_i = 32'h0000_4000; p0_be_i = 4'hF;
        step();
        #1;
        checks++;
        if ({p0_rvalid_o, p1_rvalid_o} !== 2'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_4000) begin
            failures++;
            $display("FAIL spur_req got rv0=%b rv1=%b req=%b addr=%h exp rv=0 req=1 addr=00004000",
                     p0_rvalid_o, p1_rvalid_o, mem_req_o, mem_addr_o);
        end
        step();
        mem_rvalid_i = 0; mem_gnt_i = 1;
        #1;
        checks++;
        if (p0_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL spur_gnt got g0=%b exp=1", p0_gnt_o);
        end
        step();
        p0_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        step();
        clear_inputs();
    endtask

    // Pointer is 1 on entry (last owner was p0); reset must bring it back to 0.
    task automatic test_reset_in_resp();
        p0_req_i = 1; p0_addr_i = 32'h0000_5000; p0_be_i = 4'hF; mem_gnt_i = 1;
        step();
        p0_req_i = 0; mem_gnt_i = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o} !== 5'b0) begin
            failures++;
            $display("FAIL rst_resp_out got=%b exp=00000",
                     {mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o});
        end
        step();
        rst_n = 1;
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0000;
        #1;
        checks++;
        if ({p0_rvalid_o, p1_rvalid_o} !== 2'b0 || p0_rdata_o !== '0) begin
            failures++;
            $display("FAIL rst_resp_drop got rv0=%b rv1=%b rd0=%h exp 0",
                     p0_rvalid_o, p1_rvalid_o, p0_rdata_o);
        end
        step();
        mem_rvalid_i = 0;
        p0_req_i = 1; p1_req_i = 1; p1_addr_i = 32'h0000_6000; mem_gnt_i = 1;
        #1;
        checks++;
        if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp_ptr got g0=%b g1=%b exp g0=1 g1=0", p0_gnt_o, p1_gnt_o);
        end
        step();
        p0_req_i = 0; p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        step();
        clear_inputs();
    endtask

    // Pointer is 1 on entry.
    task automatic test_error();
        p1_req_i = 1; p1_addr_i = 32'h0000_7000; p1_be_i = 4'hF; mem_gnt_i = 1;
        step();
        p1_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_error_i = 1; mem_rdata_i = 32'h0000_0055;
        #1;
        checks++;
        if (p1_rvalid_o !== 1'b1 || p1_error_o !== 1'b1 || p0_error_o !== 1'b0 || p0_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL err_resp got rv1=%b err1=%b rv0=%b err0=%b exp 1 1 0 0",
                     p1_rvalid_o, p1_error_o, p0_rvalid_o, p0_error_o);
        end
        step();
        mem_rvalid_i = 0;
        #1;
        checks++;
        if (p1_error_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL err_after got rv1=%b err1=%b exp 0 0", p1_rvalid_o, p1_error_o);
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_inputs();
        rst_n = 1;
        #3;
        test_reset();
        test_single_read();
        test_alternation();
        test_stall();
        test_spurious_rvalid();
        test_reset_in_resp();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
